// File: rtl/rc4_stream_cipher.sv
// RC4-dropN stream cipher: byte-serial key load, KSA, optional keystream discard,
// then XOR of a valid/ready data stream with the keystream (encrypt == decrypt).
module rc4_stream_cipher #(
    parameter int KEY_MAX_LEN = 16,
    parameter int DISCARD     = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_valid,
    output logic       key_ready,
    input  logic [7:0] key_byte,
    input  logic       key_last,
    input  logic       din_valid,
    output logic       din_ready,
    input  logic [7:0] din,
    output logic       dout_valid,
    input  logic       dout_ready,
    output logic [7:0] dout,
    output logic       init_done
);

    localparam int KLW = $clog2(KEY_MAX_LEN + 1);
    localparam int KIW = (KEY_MAX_LEN > 1) ? $clog2(KEY_MAX_LEN) : 1;
    localparam int DW  = 11;

    localparam logic [KLW-1:0] KEY_MAX   = KLW'(KEY_MAX_LEN);
    localparam logic [DW-1:0]  DISC_LAST = DW'((DISCARD > 0) ? DISCARD - 1 : 0);

    typedef enum logic [3:0] {
        IDLE, KEYLOAD, INIT, KSA_J, KSA_SW, DISC_A, DISC_B, READY, GEN_A, GEN_B, HOLD
    } state_t;

    state_t         state;
    logic [7:0]     s_mem   [256];
    logic [7:0]     key_mem [KEY_MAX_LEN];
    logic [7:0]     i, j, t, din_q;
    logic [KLW-1:0] key_len;
    logic [KIW-1:0] key_idx;
    logic [DW-1:0]  disc_cnt;

    logic           key_acc, din_acc, key_wr;
    logic [KIW-1:0] key_wr_idx;
    logic [KLW-1:0] key_len_m1;
    logic [7:0]     s_i, s_j, key_cur;
    logic [7:0]     i_nxt, j_nxt, s_i_nxt, s_j_nxt;

    // Data in flight has priority over a rekey when both are offered in READY.
    assign key_ready = (state == KEYLOAD) || ((state == READY) && !din_valid);
    assign din_ready = (state == READY) || ((state == HOLD) && dout_ready);
    assign init_done = state inside {READY, GEN_A, GEN_B, HOLD};

    assign key_acc    = key_valid && key_ready;
    assign din_acc    = din_valid && din_ready;
    assign key_wr     = key_acc && ((state == READY) || (key_len != KEY_MAX));
    assign key_wr_idx = (state == READY) ? '0 : key_len[KIW-1:0];
    assign key_len_m1 = key_len - KLW'(1);

    // KSA operands
    assign s_i     = s_mem[i];
    assign s_j     = s_mem[j];
    assign key_cur = key_mem[key_idx];

    // PRGA cycle A operands; when i_nxt == j_nxt both writes carry the same value
    assign i_nxt   = i + 8'd1;
    assign s_i_nxt = s_mem[i_nxt];
    assign j_nxt   = j + s_i_nxt;
    assign s_j_nxt = s_mem[j_nxt];

    // NOTE: S and key storage carry no reset; INIT rebuilds S and every key load
    // rewrites the bytes that KSA reads, so a reset here would only cost area.
    always_ff @(posedge clk) begin
        if (key_wr)
            key_mem[key_wr_idx] <= key_byte;
        case (state)
            INIT:   s_mem[i] <= i;
            KSA_SW: begin
                s_mem[i] <= s_j;
                s_mem[j] <= s_i;
            end
            DISC_A, GEN_A: begin
                s_mem[i_nxt] <= s_j_nxt;
                s_mem[j_nxt] <= s_i_nxt;
            end
            default: ;
        endcase
    end

    // NOTE: all state uses non-blocking assignments so every read in this block
    // sees the pre-edge value, matching the register-transfer intent.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            i          <= '0;
            j          <= '0;
            t          <= '0;
            key_len    <= '0;
            key_idx    <= '0;
            disc_cnt   <= '0;
            din_q      <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: state <= KEYLOAD;
                KEYLOAD: if (key_acc) begin
                    if (key_len != KEY_MAX)
                        key_len <= key_len + KLW'(1);
                    if (key_last) begin
                        i     <= '0;
                        state <= INIT;
                    end
                end
                INIT: begin
                    i <= i + 8'd1;
                    if (i == 8'hFF) begin
                        j       <= '0;
                        key_idx <= '0;
                        state   <= KSA_J;
                    end
                end
                KSA_J: begin
                    j     <= j + s_i + key_cur;
                    state <= KSA_SW;
                end
                KSA_SW: begin
                    if (i == 8'hFF) begin
                        i        <= '0;
                        j        <= '0;
                        disc_cnt <= '0;
                        state    <= (DISCARD > 0) ? DISC_A : READY;
                    end else begin
                        i       <= i + 8'd1;
                        key_idx <= (KLW'(key_idx) == key_len_m1) ? '0 : key_idx + KIW'(1);
                        state   <= KSA_J;
                    end
                end
                DISC_A, GEN_A: begin
                    i     <= i_nxt;
                    j     <= j_nxt;
                    t     <= s_i_nxt + s_j_nxt;
                    state <= (state == DISC_A) ? DISC_B : GEN_B;
                end
                DISC_B: begin
                    if (disc_cnt == DISC_LAST) begin
                        state <= READY;
                    end else begin
                        disc_cnt <= disc_cnt + DW'(1);
                        state    <= DISC_A;
                    end
                end
                READY: begin
                    if (din_acc) begin
                        din_q <= din;
                        state <= GEN_A;
                    end else if (key_acc) begin
                        key_len <= KLW'(1);
                        if (key_last) begin
                            i     <= '0;
                            state <= INIT;
                        end else begin
                            state <= KEYLOAD;
                        end
                    end
                end
                GEN_B: begin
                    dout       <= din_q ^ s_mem[t];
                    dout_valid <= 1'b1;
                    state      <= HOLD;
                end
                HOLD: if (dout_ready) begin
                    dout_valid <= 1'b0;
                    if (din_valid) begin
                        din_q <= din;
                        state <= GEN_A;
                    end else begin
                        state <= READY;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rc4_stream_cipher.sv
// Bench for rc4_stream_cipher: DISCARD=0 and DISCARD=3 instances run in lockstep
// against known vectors and a plain RC4 array model.
module tb_rc4_stream_cipher;

    localparam int KML = 16;

    typedef logic [7:0] byte_t;
    typedef struct packed {
        logic [0:19][7:0] key;
        int               klen;
        logic [0:19][7:0] data;
        int               n;
        logic [0:19][7:0] exp0;
        logic [0:19][7:0] exp3;
        bit               has_exp3;
        int               mode;
    } vec_t;

    logic clk = 1'b0, rst = 1'b0;
    logic key_valid = 1'b0, key_last = 1'b0, din_valid = 1'b0, dout_ready = 1'b0;
    logic [7:0] key_byte = '0, din = '0;
    logic key_ready0, din_ready0, dout_valid0, init_done0;
    logic key_ready3, din_ready3, dout_valid3, init_done3;
    logic [7:0] dout0, dout3;

    int n_checks = 0, n_err = 0;
    byte_t kbuf [0:31];
    byte_t dbuf [0:63];
    byte_t e0   [0:63];
    byte_t e3   [0:63];
    byte_t mks  [0:63];
    vec_t  vecs [4];

    always #5 clk = ~clk;

    rc4_stream_cipher #(.KEY_MAX_LEN(KML), .DISCARD(0)) dut0 (
        .clk(clk), .rst(rst), .key_valid(key_valid), .key_ready(key_ready0),
        .key_byte(key_byte), .key_last(key_last), .din_valid(din_valid),
        .din_ready(din_ready0), .din(din), .dout_valid(dout_valid0),
        .dout_ready(dout_ready), .dout(dout0), .init_done(init_done0));

    rc4_stream_cipher #(.KEY_MAX_LEN(KML), .DISCARD(3)) dut3 (
        .clk(clk), .rst(rst), .key_valid(key_valid), .key_ready(key_ready3),
        .key_byte(key_byte), .key_last(key_last), .din_valid(din_valid),
        .din_ready(din_ready3), .din(din), .dout_valid(dout_valid3),
        .dout_ready(dout_ready), .dout(dout3), .init_done(init_done3));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Textbook RC4 with key truncated to KML bytes; fills mks with n bytes after drop.
    function automatic void model_ks(input int klen, input int drop, input int n);
        int s [256];
        int ii, jj, tmp, kl;
        kl = (klen > KML) ? KML : klen;
        for (int x = 0; x < 256; x++) s[x] = x;
        jj = 0;
        for (int x = 0; x < 256; x++) begin
            jj = (jj + s[x] + int'(kbuf[x % kl])) % 256;
            tmp = s[x]; s[x] = s[jj]; s[jj] = tmp;
        end
        ii = 0; jj = 0;
        for (int b = 0; b < drop + n; b++) begin
            ii = (ii + 1) % 256;
            jj = (jj + s[ii]) % 256;
            tmp = s[ii]; s[ii] = s[jj]; s[jj] = tmp;
            if (b >= drop) mks[b - drop] = byte_t'(s[(s[ii] + s[jj]) % 256]);
        end
    endfunction

    function automatic void prepare_model(input int klen, input int n);
        model_ks(klen, 0, n);
        for (int b = 0; b < n; b++) e0[b] = dbuf[b] ^ mks[b];
        model_ks(klen, 3, n);
        for (int b = 0; b < n; b++) e3[b] = dbuf[b] ^ mks[b];
    endfunction

    function automatic logic [0:19][7:0] pack20(input logic [159:0] v, input int n);
        return v << (8 * (20 - n));
    endfunction

    function automatic logic [0:19][7:0] str20(input string s);
        logic [0:19][7:0] r;
        r = '0;
        for (int k = 0; k < s.len() && k < 20; k++) r[k] = s[k];
        return r;
    endfunction

    function automatic vec_t make_vec(input string k, input string d, input int n,
                                      input logic [0:19][7:0] x0, input logic [0:19][7:0] x3,
                                      input bit h3, input int mode);
        vec_t v;
        v.key = str20(k); v.klen = k.len(); v.data = str20(d); v.n = n;
        v.exp0 = x0; v.exp3 = x3; v.has_exp3 = h3; v.mode = mode;
        return v;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; key_valid = 1'b0; key_last = 1'b0; din_valid = 1'b0; dout_ready = 1'b0;
        #1;
        check("rst_outs_dut0", {key_ready0, din_ready0, dout_valid0, init_done0, dout0}, 32'h0);
        check("rst_outs_dut3", {key_ready3, din_ready3, dout_valid3, init_done3, dout3}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic send_key(input int klen);
        int cnt;
        for (int b = 0; b < klen; b++) begin
            @(negedge clk);
            key_valid = 1'b1; key_byte = kbuf[b]; key_last = (b == klen - 1);
            #1;
            cnt = 0;
            while (!(key_ready0 && key_ready3) && cnt < 100) begin
                @(negedge clk); #1; cnt++;
            end
            if (cnt >= 100) check("key_accept_timeout", 0, 1);
            @(posedge clk);
        end
    endtask

    task automatic wait_init();
        int k = 0, t0 = -1, t3 = -1;
        while ((t0 < 0 || t3 < 0) && k < 2000) begin
            @(negedge clk);
            key_valid = 1'b0; key_last = 1'b0;
            #1;
            if (init_done0 && t0 < 0) t0 = k;
            if (init_done3 && t3 < 0) t3 = k;
            k++;
        end
        check("init_done_cycles_drop0", t0, 256 + 512);
        check("init_done_cycles_drop3", t3, 256 + 512 + 6);
    endtask

    // mode 0: dout_ready held high, 1: toggled 1/0 each cycle, 2: random
    task automatic run_data(input int n, input int mode);
        int sent = 0, got = 0, cyc = 0, in_cyc = -1, out1 = -1, out2 = -1;
        bit holding = 1'b0;
        byte_t held = '0;
        while (got < n && cyc < 20 * n + 50) begin
            @(negedge clk);
            din_valid  = (sent < n);
            din        = dbuf[sent];
            dout_ready = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 2 == 0) : 1'($urandom_range(0, 1));
            #1;
            if (holding) check("dout_stable", {dout_valid0, dout0}, {1'b1, held});
            if (dout_valid0 && dout_ready) begin
                check("dout_drop0", dout0, e0[got]);
                check("dout_drop3", {dout_valid3, dout3}, {1'b1, e3[got]});
                if (got == 0) out1 = cyc;
                if (got == 1) out2 = cyc;
                got++;
                holding = 1'b0;
            end else begin
                holding = dout_valid0;
                held    = dout0;
            end
            if (din_valid && din_ready0) begin
                if (sent == 0) in_cyc = cyc;
                sent++;
            end
            cyc++;
        end
        check("byte_count", got, n);
        if (mode == 0) begin
            // accept decided one half-cycle before its edge; dout_valid follows two edges later
            check("latency", out1 - in_cyc, 3);
            if (n > 1) check("throughput", out2 - out1, 3);
        end
    endtask

    task automatic run_vec(input vec_t v, input bit with_reset);
        for (int b = 0; b < 20; b++) begin
            kbuf[b] = v.key[b];
            dbuf[b] = v.data[b];
        end
        prepare_model(v.klen, v.n);
        for (int b = 0; b < v.n; b++) begin
            e0[b] = v.exp0[b];
            if (v.has_exp3) e3[b] = v.exp3[b];
        end
        if (with_reset) do_reset();
        send_key(v.klen);
        wait_init();
        run_data(v.n, v.mode);
    endtask

    initial begin
        vecs[0] = make_vec("Key", "", 10,
            pack20({8'hEB, 8'h9F, 8'h77, 8'h81, 8'hB7, 8'h34, 8'hCA, 8'h72, 8'hA7, 8'h19}, 10),
            '0, 1'b0, 0);
        vecs[1] = make_vec("Secret", "Attack at dawn", 14,
            pack20({8'h45, 8'hA0, 8'h1F, 8'h64, 8'h5F, 8'hC3, 8'h5B, 8'h38, 8'h35, 8'h52,
                    8'h54, 8'h4B, 8'h9B, 8'hF5}, 14),
            '0, 1'b0, 2);
        vecs[2] = make_vec("Wiki", "pedia", 5,
            pack20({8'h10, 8'h21, 8'hBF, 8'h04, 8'h20}, 5), '0, 1'b0, 1);
        vecs[3] = make_vec("Key", "", 7,
            pack20({8'hEB, 8'h9F, 8'h77, 8'h81, 8'hB7, 8'h34, 8'hCA}, 7),
            pack20({8'h81, 8'hB7, 8'h34, 8'hCA, 8'h72, 8'hA7, 8'h19}, 7), 1'b1, 0);

        for (int v = 0; v < 4; v++) run_vec(vecs[v], 1'b1);

        // Reset in the middle of KSA, then reload the same key without a further reset
        for (int b = 0; b < 20; b++) kbuf[b] = vecs[0].key[b];
        send_key(3);
        repeat (300) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("mid_ksa_rst_dut0", {key_ready0, din_ready0, dout_valid0, init_done0, dout0}, 32'h0);
        check("mid_ksa_rst_dut3", {key_ready3, din_ready3, dout_valid3, init_done3, dout3}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        run_vec(vecs[0], 1'b0);

        // Five bytes of "Key", then rekey "Wiki" straight from READY
        run_vec(make_vec("Key", "", 5,
            pack20({8'hEB, 8'h9F, 8'h77, 8'h81, 8'hB7}, 5), '0, 1'b0, 0), 1'b1);
        run_vec(make_vec("Wiki", "", 4,
            pack20({8'h60, 8'h44, 8'hDB, 8'h6D}, 4), '0, 1'b0, 0), 1'b0);

        // 20-byte key: stream must equal that of its first 16 bytes alone
        for (int b = 0; b < 20; b++) kbuf[b] = byte_t'($urandom);
        for (int b = 0; b < 12; b++) dbuf[b] = byte_t'($urandom);
        prepare_model(16, 12);
        do_reset();
        send_key(20);
        wait_init();
        run_data(12, 2);

        // Random keys, payloads and back-pressure
        for (int it = 0; it < 6; it++) begin
            int kl, n, mode;
            kl   = $urandom_range(1, 20);
            n    = $urandom_range(1, 16);
            mode = $urandom_range(0, 2);
            for (int b = 0; b < 20; b++) kbuf[b] = byte_t'($urandom);
            for (int b = 0; b < n; b++) dbuf[b] = byte_t'($urandom);
            prepare_model(kl, n);
            do_reset();
            send_key(kl);
            wait_init();
            run_data(n, mode);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
